snitch_icache_refill_engine: RTL
================================

Name: snitch_icache_refill_engine

Overview:
- Downstream neighbour of the icache miss handler. Consumes its refill requests (line address plus pending-table index) and turns each into one burst read on a narrower memory bus.
- Assembles the returned beats into a full cache line and returns it with the original index and an error flag on the handler's refill-response port.
- Supports several outstanding bursts. Responses are returned in issue order.

Parameters:
- FETCH_AW, 32: fetch/line address width.
- LINE_WIDTH, 128: cache line width in bits.
- MEM_DW, 64: memory data width; LINE_WIDTH must be a multiple of MEM_DW.
- PENDING_IW, 2: refill ID width (pending-table index).
- MAX_OUTSTANDING, 4: maximum number of bursts issued but not yet returned; power of two, at least 1.

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: asynchronous active-low reset.
- in_req_addr_i, in, FETCH_AW: requested line address; low bits may be unaligned.
- in_req_id_i, in, PENDING_IW: refill ID.
- in_req_valid_i, in, 1: request valid.
- in_req_ready_o, out, 1: request ready.
- in_rsp_data_o, out, LINE_WIDTH: assembled line.
- in_rsp_error_o, out, 1: line error.
- in_rsp_id_o, out, PENDING_IW: ID of the returned line.
- in_rsp_valid_o, out, 1: response valid.
- in_rsp_ready_i, in, 1: response ready.
- mem_ar_addr_o, out, FETCH_AW: burst start address, line aligned.
- mem_ar_len_o, out, 8: beats minus 1.
- mem_ar_valid_o, out, 1: burst request valid.
- mem_ar_ready_i, in, 1: burst request ready.
- mem_r_data_i, in, MEM_DW: beat data.
- mem_r_error_i, in, 1: beat error.
- mem_r_last_i, in, 1: last beat of burst.
- mem_r_valid_i, in, 1: beat valid.
- mem_r_ready_o, out, 1: beat ready.

Behaviour:
- Derived constants:
  - BEATS = LINE_WIDTH/MEM_DW.
  - LINE_ALIGN = log2(LINE_WIDTH/8).
- Reset: async, active-low. All valid outputs are 0; the beat counter, error accumulator and ID FIFO are empty; the line buffer is zeroed.
- Reset mid-operation drops all in-flight state. The memory side must be reset together with this block.
- Request issue (combinational pass-through, zero latency):
  - mem_ar_valid_o = in_req_valid_i && !fifo_full.
  - in_req_ready_o = mem_ar_ready_i && !fifo_full.
  - mem_ar_addr_o = in_req_addr_i with the low LINE_ALIGN bits cleared.
  - mem_ar_len_o = BEATS-1.
  - On AR handshake, push in_req_id_i into the ID FIFO.
- Beat assembly:
  - Registered beat counter cnt_q runs 0..BEATS-1.
  - mem_r_ready_o = !line_valid_q || in_rsp_ready_i.
  - On R handshake, write mem_r_data_i into line slice [cnt_q*MEM_DW +: MEM_DW], so beat 0 lands in the LSBs.
  - err_q |= mem_r_error_i, plus a last-mismatch error: mem_r_last_i != (cnt_q==BEATS-1).
  - cnt_q is authoritative; mem_r_last_i is checked only.
- Line completion:
  - On accepting the beat with cnt_q==BEATS-1: cnt_q wraps to 0 and line_valid_q is set the next cycle.
  - The accumulated error is moved to the output register and err_q is cleared for the next line.
  - Latency: in_rsp_valid_o rises one cycle after the final beat handshake.
- Response:
  - in_rsp_valid_o = line_valid_q; data and error come from registers; in_rsp_id_o = FIFO head.
  - On in_rsp handshake, pop the FIFO and clear line_valid_q, unless a new final beat completes in the same cycle; then line_valid_q stays 1.
  - Full throughput: the next line's beats are accepted while the current line waits.
  - The line output register must be separate from the assembly buffer, or the assembly must not overwrite the held line. Required: in_rsp_data_o stays stable while valid && !ready.
- Backpressure: while line_valid_q && !in_rsp_ready_i, further beats may be accepted only if they are not the final beat of the next line.
  - Simplest compliant rule: mem_r_ready_o = 0 when the incoming beat would complete a line while the output is held.
- Boundaries:
  - With BEATS==1, every beat completes a line.
  - FIFO full blocks AR only; R continues.
  - Same-cycle AR push and response pop are both legal.
  - An R beat while the FIFO is empty is a protocol violation: simulation assertion; behaviour unspecified.
  - Bursts return in order; no ID reordering.

Decomposition:
- snitch_icache_pkg gains a refill_req_t struct (addr, id) and a BEATS/LINE_ALIGN helper.
- ID tracking uses common_cells fifo_v3 (DEPTH=MAX_OUTSTANDING, DATA_WIDTH=PENDING_IW) as the single sub-module.
- Beat assembly and the output register stay in this module.

Test Plan:
- Single refill: addr 0x1000_0014, id 2; beats 0x1111_1111_1111_1111, 0x2222_2222_2222_2222 with last on beat 1 -> AR addr 0x1000_0010, len 1; response data 0x2222..._1111..., id 2, error 0, valid one cycle after beat 1.
- Outstanding limit: ids 0..4 back to back, AR always ready, R withheld -> 4 ARs accepted, in_req_ready_o=0 for id 4 until the first response handshake; responses return ids 0,1,2,3 in order.
- Error accumulation: line 1 with mem_r_error_i=1 on beat 0 only, line 2 clean -> line 1 error=1, line 2 error=0.
- Backpressure: in_rsp_ready_i=0 for 5 cycles with two lines streamed -> first line data stable, final beat of second line stalled via mem_r_ready_o=0; once ready rises, lines delivered on consecutive handshakes.
- Early last: mem_r_last_i=1 on beat 0 -> no completion until beat 1, response error=1.
- Reset mid-burst: rst_ni low after one beat -> all valids 0, cnt 0, FIFO empty; a fresh refill after reset completes normally.

Source files
------------

// File: rtl/snitch_icache_pkg.sv
// Shared types and helpers for the snitch instruction cache refill path.
package snitch_icache_pkg;

   localparam int unsigned DEF_FETCH_AW   = 32;
   localparam int unsigned DEF_PENDING_IW = 2;

   // Refill request as issued by the miss handler: line address plus pending-table index.
   typedef struct packed {
      logic [DEF_FETCH_AW-1:0]   addr;
      logic [DEF_PENDING_IW-1:0] id;
   } refill_req_t;

   // Number of memory beats needed to fill one cache line.
   function automatic int unsigned refill_beats(input int unsigned line_width,
                                                input int unsigned mem_dw);
      return line_width / mem_dw;
   endfunction

   // Number of address LSBs covered by one cache line.
   function automatic int unsigned refill_line_align(input int unsigned line_width);
      return $clog2(line_width / 8);
   endfunction

endpackage

// File: rtl/fifo_v3.sv
// Minimal non-fall-through FIFO, port compatible with the common_cells fifo_v3 subset used here.
module fifo_v3 #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   output logic                  full_o,
   output logic                  empty_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  push_i,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  pop_i
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

   logic [AW-1:0]         rd_q, wr_q;
   logic [AW:0]           cnt_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  push_ok, pop_ok;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign data_o  = mem_q[rd_q];
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // Storage, pointers and fill level; push and pop may happen in the same cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= (wr_q == LAST_PTR) ? '0 : wr_q + AW'(1);
         end
         if (pop_ok) rd_q <= (rd_q == LAST_PTR) ? '0 : rd_q + AW'(1);
         if (push_ok && !pop_ok)      cnt_q <= cnt_q + (AW+1)'(1);
         else if (pop_ok && !push_ok) cnt_q <= cnt_q - (AW+1)'(1);
      end
   end

endmodule

// File: rtl/snitch_icache_refill_engine.sv
// Turns icache refill requests into memory bursts and reassembles the beats into lines.
module snitch_icache_refill_engine
   import snitch_icache_pkg::*;
#(
   parameter int unsigned FETCH_AW        = 32,
   parameter int unsigned LINE_WIDTH      = 128,
   parameter int unsigned MEM_DW          = 64,
   parameter int unsigned PENDING_IW      = 2,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [FETCH_AW-1:0]   in_req_addr_i,
   input  logic [PENDING_IW-1:0] in_req_id_i,
   input  logic                  in_req_valid_i,
   output logic                  in_req_ready_o,
   output logic [LINE_WIDTH-1:0] in_rsp_data_o,
   output logic                  in_rsp_error_o,
   output logic [PENDING_IW-1:0] in_rsp_id_o,
   output logic                  in_rsp_valid_o,
   input  logic                  in_rsp_ready_i,
   output logic [FETCH_AW-1:0]   mem_ar_addr_o,
   output logic [7:0]            mem_ar_len_o,
   output logic                  mem_ar_valid_o,
   input  logic                  mem_ar_ready_i,
   input  logic [MEM_DW-1:0]     mem_r_data_i,
   input  logic                  mem_r_error_i,
   input  logic                  mem_r_last_i,
   input  logic                  mem_r_valid_i,
   output logic                  mem_r_ready_o
);

   localparam int unsigned BEATS      = refill_beats(LINE_WIDTH, MEM_DW);
   localparam int unsigned LINE_ALIGN = refill_line_align(LINE_WIDTH);
   localparam int unsigned CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0]    LAST_CNT   = CNT_W'(BEATS - 1);
   localparam logic [FETCH_AW-1:0] ALIGN_MASK = {FETCH_AW{1'b1}} << LINE_ALIGN;

   logic                  fifo_full, fifo_empty;
   logic [PENDING_IW-1:0] fifo_head;
   logic                  ar_hs, r_hs, rsp_hs, final_beat;

   logic [CNT_W-1:0]      cnt_q;
   logic                  err_q, err_next;
   logic [LINE_WIDTH-1:0] asm_q, line_next;
   logic [LINE_WIDTH-1:0] data_q;
   logic                  err_out_q;
   logic                  line_valid_q;

   // Request issue is a pure pass-through gated only by ID-FIFO space.
   assign mem_ar_valid_o = in_req_valid_i && !fifo_full;
   assign in_req_ready_o = mem_ar_ready_i && !fifo_full;
   assign mem_ar_addr_o  = in_req_addr_i & ALIGN_MASK;
   assign mem_ar_len_o   = 8'(BEATS - 1);
   assign ar_hs          = in_req_valid_i && mem_ar_ready_i && !fifo_full;

   assign final_beat = (cnt_q == LAST_CNT);
   // Non-final beats may always land in the assembly buffer; only a beat that would
   // complete a line must wait while the previous line is still held.
   assign mem_r_ready_o = !line_valid_q || in_rsp_ready_i || !final_beat;
   assign r_hs          = mem_r_valid_i && mem_r_ready_o;
   assign rsp_hs        = line_valid_q && in_rsp_ready_i;

   assign in_rsp_valid_o = line_valid_q;
   assign in_rsp_data_o  = data_q;
   assign in_rsp_error_o = err_out_q;
   assign in_rsp_id_o    = fifo_head;

   fifo_v3 #(
      .DATA_WIDTH (PENDING_IW),
      .DEPTH      (MAX_OUTSTANDING)
   ) i_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (1'b0),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .data_i  (in_req_id_i),
      .push_i  (ar_hs),
      .data_o  (fifo_head),
      .pop_i   (rsp_hs)
   );

   // Line as it looks with the current beat merged in, plus the updated error.
   always_comb begin
      line_next = asm_q;
      line_next[int'(cnt_q) * MEM_DW +: MEM_DW] = mem_r_data_i;
      err_next = err_q | mem_r_error_i | (mem_r_last_i != final_beat);
   end

   // Beat counter, assembly buffer, error accumulator and the held output line.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q        <= '0;
         err_q        <= 1'b0;
         asm_q        <= '0;
         data_q       <= '0;
         err_out_q    <= 1'b0;
         line_valid_q <= 1'b0;
      end else begin
         if (r_hs) begin
            asm_q <= line_next;
            if (final_beat) begin
               cnt_q     <= '0;
               err_q     <= 1'b0;
               data_q    <= line_next;
               err_out_q <= err_next;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
               err_q <= err_next;
            end
         end
         if (r_hs && final_beat) line_valid_q <= 1'b1;
         else if (rsp_hs)        line_valid_q <= 1'b0;
      end
   end

   r_beat_has_owner : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                       mem_r_valid_i |-> !fifo_empty);

endmodule
